// File: rtl/rs_multi_cdb.sv
// Reservation station with two-bus operand wakeup and insert-time forwarding.
// It issues the oldest ready entry, relative to rob_head, into a registered valid/ready issue port.
module rs_multi_cdb #(
  parameter int CAP    = 8,
  parameter int CAP_W  = 3,
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              ins_valid,
  input  logic [TYPE_W-1:0] ins_type,
  input  logic [ROB_W-1:0]  ins_rob_id,
  input  logic [DATA_W-1:0] ins_v1,
  input  logic [DATA_W-1:0] ins_v2,
  input  logic              ins_has_dep1,
  input  logic              ins_has_dep2,
  input  logic [ROB_W-1:0]  ins_dep1,
  input  logic [ROB_W-1:0]  ins_dep2,
  input  logic              cdb0_valid,
  input  logic [ROB_W-1:0]  cdb0_rob_id,
  input  logic [DATA_W-1:0] cdb0_val,
  input  logic              cdb1_valid,
  input  logic [ROB_W-1:0]  cdb1_rob_id,
  input  logic [DATA_W-1:0] cdb1_val,
  output logic              full,
  output logic [CAP_W:0]    count,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [TYPE_W-1:0] iss_type,
  output logic [ROB_W-1:0]  iss_rob_id,
  output logic [DATA_W-1:0] iss_v1,
  output logic [DATA_W-1:0] iss_v2
);

  logic [CAP-1:0]    busy_q, busy_d;
  logic [CAP-1:0]    hd1_q, hd1_d;
  logic [CAP-1:0]    hd2_q, hd2_d;
  logic [TYPE_W-1:0] type_q [CAP];
  logic [TYPE_W-1:0] type_d [CAP];
  logic [ROB_W-1:0]  rob_q  [CAP];
  logic [ROB_W-1:0]  rob_d  [CAP];
  logic [ROB_W-1:0]  dep1_q [CAP];
  logic [ROB_W-1:0]  dep1_d [CAP];
  logic [ROB_W-1:0]  dep2_q [CAP];
  logic [ROB_W-1:0]  dep2_d [CAP];
  logic [DATA_W-1:0] v1_q   [CAP];
  logic [DATA_W-1:0] v1_d   [CAP];
  logic [DATA_W-1:0] v2_q   [CAP];
  logic [DATA_W-1:0] v2_d   [CAP];

  logic [CAP_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              iss_valid_q, iss_valid_d;
  logic [TYPE_W-1:0] iss_type_q, iss_type_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;
  logic [DATA_W-1:0] iss_v1_q, iss_v1_d;
  logic [DATA_W-1:0] iss_v2_q, iss_v2_d;

  logic [CAP-1:0]    ready;
  logic [ROB_W-1:0]  age [CAP];
  logic              sel_found;
  logic [CAP_W-1:0]  sel_idx;
  logic [ROB_W-1:0]  sel_age;
  logic              free_found;
  logic [CAP_W-1:0]  free_idx;
  logic              ins_acc;
  logic              iss_load;
  logic [DATA_W-1:0] fwd_v1, fwd_v2;
  logic              fwd_hd1, fwd_hd2;

  // Age is the modular distance from the ROB head, so wrap-around orders correctly.
  for (genvar g = 0; g < CAP; g++) begin : g_entry
    assign ready[g] = busy_q[g] & ~hd1_q[g] & ~hd2_q[g];
    assign age[g]   = rob_q[g] - rob_head;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < CAP; i++) begin
      if (ready[i] && (!sel_found || age[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = CAP_W'(i);
        sel_age   = age[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = CAP - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = CAP_W'(i);
      end
    end
  end

  // A broadcast on the insert cycle would otherwise be missed by the new entry.
  always_comb begin
    fwd_v1  = ins_v1;
    fwd_hd1 = ins_has_dep1;
    fwd_v2  = ins_v2;
    fwd_hd2 = ins_has_dep2;
    if (ins_has_dep1) begin
      if (cdb0_valid && cdb0_rob_id == ins_dep1) begin
        fwd_v1  = cdb0_val;
        fwd_hd1 = 1'b0;
      end else if (cdb1_valid && cdb1_rob_id == ins_dep1) begin
        fwd_v1  = cdb1_val;
        fwd_hd1 = 1'b0;
      end
    end
    if (ins_has_dep2) begin
      if (cdb0_valid && cdb0_rob_id == ins_dep2) begin
        fwd_v2  = cdb0_val;
        fwd_hd2 = 1'b0;
      end else if (cdb1_valid && cdb1_rob_id == ins_dep2) begin
        fwd_v2  = cdb1_val;
        fwd_hd2 = 1'b0;
      end
    end
  end

  assign ins_acc  = rdy_in & ~clear & ins_valid & ~full_q & free_found;
  assign iss_load = rdy_in & ~clear & sel_found & (~iss_valid_q | iss_ready);

  always_comb begin
    busy_d      = busy_q;
    hd1_d       = hd1_q;
    hd2_d       = hd2_q;
    type_d      = type_q;
    rob_d       = rob_q;
    dep1_d      = dep1_q;
    dep2_d      = dep2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    count_d     = count_q;
    full_d      = full_q;
    iss_valid_d = iss_valid_q;
    iss_type_d  = iss_type_q;
    iss_rob_d   = iss_rob_q;
    iss_v1_d    = iss_v1_q;
    iss_v2_d    = iss_v2_q;
    if (clear) begin
      busy_d      = '0;
      hd1_d       = '0;
      hd2_d       = '0;
      count_d     = '0;
      full_d      = 1'b0;
      iss_valid_d = 1'b0;
      iss_type_d  = '0;
      iss_rob_d   = '0;
      iss_v1_d    = '0;
      iss_v2_d    = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < CAP; i++) begin
        if (busy_q[i] && hd1_q[i]) begin
          if (cdb0_valid && cdb0_rob_id == dep1_q[i]) begin
            v1_d[i]  = cdb0_val;
            hd1_d[i] = 1'b0;
          end else if (cdb1_valid && cdb1_rob_id == dep1_q[i]) begin
            v1_d[i]  = cdb1_val;
            hd1_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && hd2_q[i]) begin
          if (cdb0_valid && cdb0_rob_id == dep2_q[i]) begin
            v2_d[i]  = cdb0_val;
            hd2_d[i] = 1'b0;
          end else if (cdb1_valid && cdb1_rob_id == dep2_q[i]) begin
            v2_d[i]  = cdb1_val;
            hd2_d[i] = 1'b0;
          end
        end
      end
      if (iss_load) begin
        busy_d[sel_idx] = 1'b0;
        iss_valid_d     = 1'b1;
        iss_type_d      = type_q[sel_idx];
        iss_rob_d       = rob_q[sel_idx];
        iss_v1_d        = v1_q[sel_idx];
        iss_v2_d        = v2_q[sel_idx];
      end else if (iss_valid_q && iss_ready) begin
        iss_valid_d = 1'b0;
      end
      // The free slot comes from start-of-cycle busy flags, so a slot vacated this cycle waits one edge.
      if (ins_acc) begin
        busy_d[free_idx] = 1'b1;
        type_d[free_idx] = ins_type;
        rob_d[free_idx]  = ins_rob_id;
        dep1_d[free_idx] = ins_dep1;
        dep2_d[free_idx] = ins_dep2;
        v1_d[free_idx]   = fwd_v1;
        v2_d[free_idx]   = fwd_v2;
        hd1_d[free_idx]  = fwd_hd1;
        hd2_d[free_idx]  = fwd_hd2;
      end
      count_d = count_q + (CAP_W+1)'(ins_acc) - (CAP_W+1)'(iss_load);
      full_d  = (count_d == (CAP_W+1)'(CAP));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      hd1_q       <= '0;
      hd2_q       <= '0;
      for (int i = 0; i < CAP; i++) begin
        type_q[i] <= '0;
        rob_q[i]  <= '0;
        dep1_q[i] <= '0;
        dep2_q[i] <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
      end
      count_q     <= '0;
      full_q      <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_type_q  <= '0;
      iss_rob_q   <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      hd1_q       <= hd1_d;
      hd2_q       <= hd2_d;
      type_q      <= type_d;
      rob_q       <= rob_d;
      dep1_q      <= dep1_d;
      dep2_q      <= dep2_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      count_q     <= count_d;
      full_q      <= full_d;
      iss_valid_q <= iss_valid_d;
      iss_type_q  <= iss_type_d;
      iss_rob_q   <= iss_rob_d;
      iss_v1_q    <= iss_v1_d;
      iss_v2_q    <= iss_v2_d;
    end
  end

  assign full       = full_q;
  assign count      = count_q;
  assign iss_valid  = iss_valid_q;
  assign iss_type   = iss_type_q;
  assign iss_rob_id = iss_rob_q;
  assign iss_v1     = iss_v1_q;
  assign iss_v2     = iss_v2_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Testbench for rs_multi_cdb: directed scenarios plus a randomized run
// checked against an age-ordered behavioural model.
module tb_rs_multi_cdb;

  localparam int CAP    = 8;
  localparam int CAP_W  = 3;
  localparam int ROB_W  = 4;
  localparam int TYPE_W = 6;
  localparam int DATA_W = 32;

  logic              clk_in;
  logic              rst_in;
  logic              rdy_in;
  logic              clear;
  logic [ROB_W-1:0]  rob_head;
  logic              ins_valid;
  logic [TYPE_W-1:0] ins_type;
  logic [ROB_W-1:0]  ins_rob_id;
  logic [DATA_W-1:0] ins_v1, ins_v2;
  logic              ins_has_dep1, ins_has_dep2;
  logic [ROB_W-1:0]  ins_dep1, ins_dep2;
  logic              cdb0_valid, cdb1_valid;
  logic [ROB_W-1:0]  cdb0_rob_id, cdb1_rob_id;
  logic [DATA_W-1:0] cdb0_val, cdb1_val;
  logic              full;
  logic [CAP_W:0]    count;
  logic              iss_valid;
  logic              iss_ready;
  logic [TYPE_W-1:0] iss_type;
  logic [ROB_W-1:0]  iss_rob_id;
  logic [DATA_W-1:0] iss_v1, iss_v2;

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents plus the issue register.
  bit                m_busy [CAP];
  bit                m_h1   [CAP];
  bit                m_h2   [CAP];
  logic [TYPE_W-1:0] m_type [CAP];
  logic [ROB_W-1:0]  m_rob  [CAP];
  logic [ROB_W-1:0]  m_d1   [CAP];
  logic [ROB_W-1:0]  m_d2   [CAP];
  logic [DATA_W-1:0] m_v1   [CAP];
  logic [DATA_W-1:0] m_v2   [CAP];
  bit                m_iv;
  logic [TYPE_W-1:0] m_it;
  logic [ROB_W-1:0]  m_ir;
  logic [DATA_W-1:0] m_iv1, m_iv2;
  int                m_count;

  rs_multi_cdb #(.CAP(CAP), .CAP_W(CAP_W), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .rob_head(rob_head),
    .ins_valid(ins_valid), .ins_type(ins_type), .ins_rob_id(ins_rob_id),
    .ins_v1(ins_v1), .ins_v2(ins_v2), .ins_has_dep1(ins_has_dep1), .ins_has_dep2(ins_has_dep2),
    .ins_dep1(ins_dep1), .ins_dep2(ins_dep2),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_val(cdb0_val),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_val(cdb1_val),
    .full(full), .count(count), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_type(iss_type), .iss_rob_id(iss_rob_id), .iss_v1(iss_v1), .iss_v2(iss_v2)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear = 1'b0; ins_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    ins_type = '0; ins_rob_id = '0; ins_v1 = '0; ins_v2 = '0;
    ins_has_dep1 = 1'b0; ins_has_dep2 = 1'b0; ins_dep1 = '0; ins_dep2 = '0;
    cdb0_rob_id = '0; cdb1_rob_id = '0; cdb0_val = '0; cdb1_val = '0;
  endtask

  task automatic set_ins(input logic [ROB_W-1:0] rob, input logic [TYPE_W-1:0] t,
                         input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                         input logic h1, input logic [ROB_W-1:0] d1,
                         input logic h2, input logic [ROB_W-1:0] d2);
    ins_valid = 1'b1; ins_rob_id = rob; ins_type = t; ins_v1 = v1; ins_v2 = v2;
    ins_has_dep1 = h1; ins_dep1 = d1; ins_has_dep2 = h2; ins_dep2 = d2;
  endtask

  task automatic flush();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_iss_valid: got %0b want 0", iss_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL rst_full: got %0b want 0", full); end
    total++; if (iss_rob_id !== 4'd0) begin bad++; $display("[TB] FAIL rst_iss_rob: got %0d want 0", iss_rob_id); end
    total++; if (iss_type !== 6'd0) begin bad++; $display("[TB] FAIL rst_iss_type: got %0d want 0", iss_type); end
    total++; if (iss_v1 !== 32'd0 || iss_v2 !== 32'd0) begin bad++; $display("[TB] FAIL rst_iss_vals: got %h/%h want 0/0", iss_v1, iss_v2); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    flush();
    rob_head = 4'd0; iss_ready = 1'b0;
    set_ins(4'd1, 6'd1, 32'h1, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    set_ins(4'd2, 6'd2, 32'h2, 32'h2, 1'b1, 4'd9, 1'b0, 4'd0); tick();
    set_ins(4'd3, 6'd3, 32'h3, 32'h3, 1'b1, 4'd9, 1'b0, 4'd0); tick();
    set_ins(4'd4, 6'd4, 32'h4, 32'h4, 1'b1, 4'd9, 1'b0, 4'd0); tick();
    ins_valid = 1'b0;
    total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL arst_pre_count: got %0d want 3", count); end
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd1) begin bad++; $display("[TB] FAIL arst_pre_iss: got v=%0b rob=%0d want v=1 rob=1", iss_valid, iss_rob_id); end
    #2 rst_in = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_iss_valid: got %0b want 0", iss_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL arst_count: got %0d want 0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL arst_full: got %0b want 0", full); end
    #1 rst_in = 1'b1;
    iss_ready = 1'b1;
    tick();
    total++; if (iss_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL arst_after: got v=%0b cnt=%0d want v=0 cnt=0", iss_valid, count); end
  endtask

  task automatic test_simple_issue();
    flush();
    rob_head = 4'd0; iss_ready = 1'b1;
    set_ins(4'd5, 6'h07, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    ins_valid = 1'b0;
    total++; if (iss_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("[TB] FAIL simple_n: got v=%0b cnt=%0d want v=0 cnt=1", iss_valid, count); end
    tick();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("[TB] FAIL simple_valid: got %0b want 1", iss_valid); end
    total++; if (iss_rob_id !== 4'd5 || iss_type !== 6'h07) begin bad++; $display("[TB] FAIL simple_tag: got rob=%0d type=%h want rob=5 type=07", iss_rob_id, iss_type); end
    total++; if (iss_v1 !== 32'h11 || iss_v2 !== 32'h22) begin bad++; $display("[TB] FAIL simple_vals: got %h/%h want 11/22", iss_v1, iss_v2); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL simple_count: got %0d want 0", count); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL simple_drain: got %0b want 0", iss_valid); end
  endtask

  task automatic test_forward();
    flush();
    rob_head = 4'd0; iss_ready = 1'b1;
    set_ins(4'd3, 6'h0A, 32'h0, 32'h33, 1'b1, 4'd7, 1'b0, 4'd0);
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd7; cdb0_val = 32'hDEADBEEF;
    tick();
    ins_valid = 1'b0; cdb0_valid = 1'b0;
    total++; if (count !== 4'd1 || iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL fwd_n: got cnt=%0d v=%0b want cnt=1 v=0", count, iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd3) begin bad++; $display("[TB] FAIL fwd_iss: got v=%0b rob=%0d want v=1 rob=3", iss_valid, iss_rob_id); end
    total++; if (iss_v1 !== 32'hDEADBEEF || iss_v2 !== 32'h33) begin bad++; $display("[TB] FAIL fwd_vals: got %h/%h want deadbeef/33", iss_v1, iss_v2); end
    set_ins(4'd4, 6'h01, 32'h0, 32'h0, 1'b1, 4'd9, 1'b1, 4'd9);
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd9; cdb0_val = 32'hA0A0A0A0;
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd9; cdb1_val = 32'hB0B0B0B0;
    tick();
    ins_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd4) begin bad++; $display("[TB] FAIL fwd_prio_iss: got v=%0b rob=%0d want v=1 rob=4", iss_valid, iss_rob_id); end
    total++; if (iss_v1 !== 32'hA0A0A0A0 || iss_v2 !== 32'hA0A0A0A0) begin bad++; $display("[TB] FAIL fwd_prio_vals: got %h/%h want a0a0a0a0/a0a0a0a0", iss_v1, iss_v2); end
    set_ins(4'd6, 6'h02, 32'h55, 32'h0, 1'b0, 4'd2, 1'b1, 4'd2);
    tick();
    ins_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd2; cdb0_val = 32'hC0;
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd2; cdb1_val = 32'hD0;
    tick();
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd6) begin bad++; $display("[TB] FAIL wake_iss: got v=%0b rob=%0d want v=1 rob=6", iss_valid, iss_rob_id); end
    total++; if (iss_v1 !== 32'h55 || iss_v2 !== 32'hC0) begin bad++; $display("[TB] FAIL wake_vals: got %h/%h want 55/c0", iss_v1, iss_v2); end
  endtask

  task automatic test_age_order();
    flush();
    rob_head = 4'd14; iss_ready = 1'b1;
    set_ins(4'd1, 6'h01, 32'h0, 32'h1, 1'b1, 4'd9, 1'b0, 4'd0); tick();
    set_ins(4'd15, 6'h0F, 32'h0, 32'hF, 1'b1, 4'd9, 1'b0, 4'd0); tick();
    ins_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd9; cdb0_val = 32'h99;
    tick();
    cdb0_valid = 1'b0;
    total++; if (iss_valid !== 1'b0 || count !== 4'd2) begin bad++; $display("[TB] FAIL age_wake: got v=%0b cnt=%0d want v=0 cnt=2", iss_valid, count); end
    tick();
    total++; if (iss_rob_id !== 4'd15 || iss_v1 !== 32'h99) begin bad++; $display("[TB] FAIL age_first: got rob=%0d v1=%h want rob=15 v1=99", iss_rob_id, iss_v1); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd1 || count !== 4'd0) begin bad++; $display("[TB] FAIL age_second: got v=%0b rob=%0d cnt=%0d want v=1 rob=1 cnt=0", iss_valid, iss_rob_id, count); end
  endtask

  task automatic test_backpressure();
    flush();
    rob_head = 4'd0; iss_ready = 1'b0;
    set_ins(4'd2, 6'h02, 32'h2, 32'h20, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    set_ins(4'd3, 6'h03, 32'h3, 32'h30, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    set_ins(4'd4, 6'h04, 32'h4, 32'h40, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    ins_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd2 || iss_v1 !== 32'h2 || iss_v2 !== 32'h20) begin bad++; $display("[TB] FAIL bp_hold%0d: got v=%0b rob=%0d v1=%h v2=%h want v=1 rob=2 v1=2 v2=20", c, iss_valid, iss_rob_id, iss_v1, iss_v2); end
      total++; if (count !== 4'd2) begin bad++; $display("[TB] FAIL bp_count%0d: got %0d want 2", c, count); end
    end
    rdy_in = 1'b0; iss_ready = 1'b1;
    set_ins(4'd6, 6'h06, 32'h6, 32'h60, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(); tick();
    total++; if (count !== 4'd2 || iss_rob_id !== 4'd2 || iss_valid !== 1'b1) begin bad++; $display("[TB] FAIL freeze: got cnt=%0d rob=%0d v=%0b want cnt=2 rob=2 v=1", count, iss_rob_id, iss_valid); end
    rdy_in = 1'b1; ins_valid = 1'b0;
    tick();
    total++; if (iss_rob_id !== 4'd3 || count !== 4'd1) begin bad++; $display("[TB] FAIL bp_accept1: got rob=%0d cnt=%0d want rob=3 cnt=1", iss_rob_id, count); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd4 || count !== 4'd0) begin bad++; $display("[TB] FAIL bp_accept2: got v=%0b rob=%0d cnt=%0d want v=1 rob=4 cnt=0", iss_valid, iss_rob_id, count); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %0b want 0", iss_valid); end
  endtask

  task automatic test_fill();
    flush();
    rob_head = 4'd0; iss_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      set_ins(ROB_W'(i), TYPE_W'(i), DATA_W'(i), DATA_W'(i), 1'b1, (i == 5) ? 4'd12 : 4'd10, 1'b0, 4'd0);
      tick();
    end
    ins_valid = 1'b0;
    total++; if (full !== 1'b1 || count !== 4'd8 || iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_full: got full=%0b cnt=%0d v=%0b want 1/8/0", full, count, iss_valid); end
    set_ins(4'd8, 6'h08, 32'h8, 32'h8, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("[TB] FAIL fill_ninth: got cnt=%0d full=%0b want 8/1", count, full); end
    set_ins(4'd9, 6'h09, 32'h99, 32'h9, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd12; cdb1_val = 32'h1234;
    tick();
    cdb1_valid = 1'b0;
    total++; if (count !== 4'd8 || iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_wake: got cnt=%0d v=%0b want 8/0", count, iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd5 || iss_v1 !== 32'h1234) begin bad++; $display("[TB] FAIL fill_issue: got v=%0b rob=%0d v1=%h want 1/5/1234", iss_valid, iss_rob_id, iss_v1); end
    total++; if (count !== 4'd7 || full !== 1'b0) begin bad++; $display("[TB] FAIL fill_drop: got cnt=%0d full=%0b want 7/0", count, full); end
    tick();
    ins_valid = 1'b0;
    total++; if (count !== 4'd8 || full !== 1'b1 || iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_reuse: got cnt=%0d full=%0b v=%0b want 8/1/0", count, full, iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_rob_id !== 4'd9 || iss_v1 !== 32'h99 || count !== 4'd7) begin bad++; $display("[TB] FAIL fill_reissue: got v=%0b rob=%0d v1=%h cnt=%0d want 1/9/99/7", iss_valid, iss_rob_id, iss_v1, count); end
    clear = 1'b1;
    set_ins(4'd11, 6'h0B, 32'hB, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    clear = 1'b0; ins_valid = 1'b0;
    total++; if (count !== 4'd0 || full !== 1'b0 || iss_valid !== 1'b0 || iss_rob_id !== 4'd0) begin bad++; $display("[TB] FAIL clear: got cnt=%0d full=%0b v=%0b rob=%0d want 0/0/0/0", count, full, iss_valid, iss_rob_id); end
    tick();
    total++; if (count !== 4'd0 || iss_valid !== 1'b0) begin bad++; $display("[TB] FAIL clear_after: got cnt=%0d v=%0b want 0/0", count, iss_valid); end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CAP; i++) begin
      m_busy[i] = 1'b0; m_h1[i] = 1'b0; m_h2[i] = 1'b0;
    end
    m_iv = 1'b0; m_it = '0; m_ir = '0; m_iv1 = '0; m_iv2 = '0; m_count = 0;
  endtask

  // Advances the model by one edge using the inputs currently applied.
  task automatic model_step();
    int sel, best, fr, a;
    logic [DATA_W-1:0] nv1, nv2;
    bit nh1, nh2;
    if (clear) begin
      model_reset();
      return;
    end
    if (!rdy_in) return;
    sel = -1; best = 1 << ROB_W;
    for (int i = 0; i < CAP; i++) begin
      if (m_busy[i] && !m_h1[i] && !m_h2[i]) begin
        a = (int'(m_rob[i]) - int'(rob_head) + (1 << ROB_W)) % (1 << ROB_W);
        if (a < best) begin best = a; sel = i; end
      end
    end
    fr = -1;
    for (int i = CAP - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
    for (int i = 0; i < CAP; i++) begin
      if (m_busy[i] && m_h1[i]) begin
        if (cdb0_valid && cdb0_rob_id == m_d1[i]) begin m_v1[i] = cdb0_val; m_h1[i] = 1'b0; end
        else if (cdb1_valid && cdb1_rob_id == m_d1[i]) begin m_v1[i] = cdb1_val; m_h1[i] = 1'b0; end
      end
      if (m_busy[i] && m_h2[i]) begin
        if (cdb0_valid && cdb0_rob_id == m_d2[i]) begin m_v2[i] = cdb0_val; m_h2[i] = 1'b0; end
        else if (cdb1_valid && cdb1_rob_id == m_d2[i]) begin m_v2[i] = cdb1_val; m_h2[i] = 1'b0; end
      end
    end
    if (sel >= 0 && (!m_iv || iss_ready)) begin
      m_iv = 1'b1; m_it = m_type[sel]; m_ir = m_rob[sel]; m_iv1 = m_v1[sel]; m_iv2 = m_v2[sel];
      m_busy[sel] = 1'b0;
      m_count--;
    end else if (m_iv && iss_ready) begin
      m_iv = 1'b0;
    end
    if (ins_valid && m_count + (m_busy[fr < 0 ? 0 : fr] ? 0 : 0) < CAP && fr >= 0) begin
      nv1 = ins_v1; nh1 = ins_has_dep1; nv2 = ins_v2; nh2 = ins_has_dep2;
      if (nh1 && cdb0_valid && cdb0_rob_id == ins_dep1) begin nv1 = cdb0_val; nh1 = 1'b0; end
      else if (nh1 && cdb1_valid && cdb1_rob_id == ins_dep1) begin nv1 = cdb1_val; nh1 = 1'b0; end
      if (nh2 && cdb0_valid && cdb0_rob_id == ins_dep2) begin nv2 = cdb0_val; nh2 = 1'b0; end
      else if (nh2 && cdb1_valid && cdb1_rob_id == ins_dep2) begin nv2 = cdb1_val; nh2 = 1'b0; end
      m_busy[fr] = 1'b1; m_type[fr] = ins_type; m_rob[fr] = ins_rob_id;
      m_d1[fr] = ins_dep1; m_d2[fr] = ins_dep2;
      m_v1[fr] = nv1; m_v2[fr] = nv2; m_h1[fr] = nh1; m_h2[fr] = nh2;
      m_count++;
    end
  endtask

  task automatic test_random();
    idle_inputs();
    clear = 1'b1;
    model_step();
    tick();
    clear = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      clear        = ($urandom_range(0, 59) == 0);
      rob_head     = ROB_W'($urandom);
      ins_valid    = ($urandom_range(0, 2) != 0);
      ins_type     = TYPE_W'($urandom);
      ins_rob_id   = ROB_W'($urandom);
      ins_v1       = $urandom;
      ins_v2       = $urandom;
      ins_has_dep1 = $urandom_range(0, 1) == 1;
      ins_has_dep2 = $urandom_range(0, 1) == 1;
      ins_dep1     = ROB_W'($urandom_range(0, 7));
      ins_dep2     = ROB_W'($urandom_range(0, 7));
      cdb0_valid   = $urandom_range(0, 1) == 1;
      cdb0_rob_id  = ROB_W'($urandom_range(0, 7));
      cdb0_val     = $urandom;
      cdb1_valid   = $urandom_range(0, 1) == 1;
      cdb1_rob_id  = ROB_W'($urandom_range(0, 7));
      cdb1_val     = $urandom;
      iss_ready    = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      total++; if (iss_valid !== m_iv) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %0b want %0b", c, iss_valid, m_iv); end
      total++; if (count !== (CAP_W+1)'(m_count)) begin bad++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", c, count, m_count); end
      total++; if (full !== (m_count == CAP)) begin bad++; $display("[TB] FAIL rnd_full c%0d: got %0b want %0b", c, full, m_count == CAP); end
      if (m_iv) begin
        total++;
        if (iss_rob_id !== m_ir || iss_type !== m_it || iss_v1 !== m_iv1 || iss_v2 !== m_iv2) begin
          bad++;
          $display("[TB] FAIL rnd_payload c%0d: got rob=%0d type=%h v1=%h v2=%h want rob=%0d type=%h v1=%h v2=%h",
                   c, iss_rob_id, iss_type, iss_v1, iss_v2, m_ir, m_it, m_iv1, m_iv2);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_in = 1'b0;
    iss_ready = 1'b0;
    rob_head = '0;
    idle_inputs();
    #12;
    test_reset();
    test_async_reset();
    test_simple_issue();
    test_forward();
    test_age_order();
    test_backpressure();
    test_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
